uart_tx_fifo_reader: RTL and testbench

UART transmit engine that drains bytes from the 32-entry UART FIFO buffer and serializes each one onto the `tx` line as a standard 8N1 (or 8N2) frame. It is the consumer of the FIFO: it issues single-cycle read requests and captures the registered byte the FIFO returns. It paces frames at a fixed clocks-per-bit rate. It sits between the FIFO's read port and the UART TX pin.

---
 rtl/uart_tx_fifo_reader.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   Pulls bytes from the UART FIFO and sends each one on the tx pin as an
//   8N1 or 8N2 frame. Every bit lasts CLKS_PER_BIT clocks. All outputs come
//   straight from flops, so tx cannot glitch.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit time (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
// Ports
//   clk                in   system clock, rising edge
//   SYS_reset_n        in   asynchronous active-low reset
//   tx_enable          in   lets a new frame start (sampled only in IDLE)
//   fifo_empty         in   FIFO empty flag (sampled only in IDLE)
//   fifo_data_valid    in   FIFO read data valid, one cycle after the request
//   fifo_data[7:0]     in   FIFO read data
//   fifo_read_request  out  single-cycle read strobe to the FIFO
//   tx                 out  serial line, idles high
//   tx_busy            out  high in every state except IDLE
//   tx_done            out  pulses in the last cycle of the last stop bit
module uart_tx_fifo_reader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       SYS_reset_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic       fifo_data_valid,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_request,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    shift_q;
  logic          tx_q, req_q, busy_q, done_q;

  logic timed, bit_end;
  assign timed   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign bit_end = timed && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      // Raised one cycle early so the registered pulse lands in the final
      // cycle of the last stop bit. CLKS_PER_BIT >= 2 keeps that cycle in
      // the same bit time.
      done_q <= (state_q == S_STOP) && (stop_q == STOP_LAST) && (cnt_q == CNT_PRE);
      // Bit-time counter runs only in the timed states and wraps to 0 at
      // every bit end, which is also every state change out of them.
      cnt_q  <= (timed && !bit_end) ? cnt_q + 1'b1 : '0;

      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_enable && !fifo_empty) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (fifo_data_valid) begin
            shift_q <= fifo_data;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end else begin
            // FIFO gave nothing back: no frame, retry from IDLE.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              stop_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_read_request = req_q;
  assign tx                = tx_q;
  assign tx_busy           = busy_q;
  assign tx_done           = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader. It builds two instances at CLKS_PER_BIT=4:
// dut1 uses one stop bit and dut2 uses two. Each instance has its own
// behavioural FIFO. Bytes are pushed to a scoreboard queue as they are
// written into a FIFO, and they are popped when a frame is decoded from tx.
module tb_uart_tx_fifo_reader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, rnd;
  logic en1, empty1, vld1, req1, tx1, busy1, done1;
  logic en2, empty2, vld2, req2, tx2, busy2, done2;
  logic [7:0] data1, data2;

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .SYS_reset_n(rst1), .tx_enable(en1), .fifo_empty(empty1),
    .fifo_data_valid(vld1), .fifo_data(data1), .fifo_read_request(req1),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .SYS_reset_n(rst2), .tx_enable(en2), .fifo_empty(empty2),
    .fifo_data_valid(vld2), .fifo_data(data2), .fifo_read_request(req2),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  // The checker looks at one instance at a time.
  logic sel;
  logic m_tx, m_busy, m_done;
  assign m_tx   = sel ? tx2   : tx1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;

  // FIFO models: data returns one cycle after the request, and empty is registered.
  logic [7:0] fq1[$], fq2[$], exp_q[$];
  bit drop1 = 1'b0;

  always @(posedge clk) begin
    if (rnd) begin
      vld1 <= 1'($urandom); data1 <= 8'($urandom); empty1 <= 1'($urandom);
    end else begin
      if (req1 && drop1) begin
        vld1 <= 1'b0; drop1 = 1'b0;
      end else if (req1 && fq1.size() > 0) begin
        data1 <= fq1.pop_front(); vld1 <= 1'b1;
      end else vld1 <= 1'b0;
      empty1 <= (fq1.size() == 0);
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      vld2 <= 1'($urandom); data2 <= 8'($urandom); empty2 <= 1'($urandom);
    end else begin
      if (req2 && fq2.size() > 0) begin
        data2 <= fq2.pop_front(); vld2 <= 1'b1;
      end else vld2 <= 1'b0;
      empty2 <= (fq2.size() == 0);
    end
  end

  // Counts of requests and done pulses, plus a watch for back-to-back requests.
  int rc1 = 0, rc2 = 0, dc1 = 0, b2b = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;
  always @(negedge clk) begin
    if (rst1 && req1) rc1++;
    if (rst2 && req2) rc2++;
    if (rst1 && done1) dc1++;
    if ((req1 && prev1) || (req2 && prev2)) b2b++;
    prev1 = req1; prev2 = req2;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] b);
    if (exp_q.size() == 0) chk(tag, int'(b), -1);
    else chk(tag, int'(b), int'(exp_q.pop_front()));
  endtask

  task automatic push1(input logic [7:0] b);
    fq1.push_back(b); exp_q.push_back(b);
  endtask

  task automatic push2(input logic [7:0] b);
    fq2.push_back(b); exp_q.push_back(b);
  endtask

  // Number of negedges until tx reads 0. The wait is bounded.
  task automatic wait_low(output int w);
    w = 0;
    while (m_tx !== 1'b0 && w < 200) begin
      @(negedge clk); w++;
    end
  endtask

  // Called on the first START cycle. Walks the whole frame cycle by cycle.
  task automatic capture(input int sb, input int drop_k, output logic [7:0] b);
    int n, dpos, dn;
    bit shape;
    logic [7:0] v;
    n = (9 + sb) * CPB; dpos = 0; dn = 0; shape = 1'b1; v = '0;
    for (int k = 1; k <= n; k++) begin
      if (k == drop_k) en1 = 1'b0;
      if (k <= CPB) begin
        if (m_tx !== 1'b0) shape = 1'b0;
      end else if (k <= 9 * CPB) begin
        if (((k - 1) % CPB) == 0) v[(k - CPB - 1) / CPB] = m_tx;
        else if (m_tx !== v[(k - CPB - 1) / CPB]) shape = 1'b0;
      end else if (m_tx !== 1'b1) shape = 1'b0;
      if (m_busy !== 1'b1) shape = 1'b0;
      if (m_done === 1'b1) begin dn++; dpos = k; end
      if (k < n) @(negedge clk);
    end
    b = v;
    chk("frame_shape", int'(shape), 1);
    chk("done_count", dn, 1);
    chk("done_pos", dpos, n);
    @(negedge clk);
    chk("busy_after", int'(m_busy), 0);
    chk("done_after", int'(m_done), 0);
  endtask

  int w, base_r, base_d;
  logic [7:0] got;

  initial begin
    sel = 1'b0; rnd = 1'b1; rst1 = 1'b0; rst2 = 1'b0; en1 = 1'b0; en2 = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en1 = 1'($urandom); en2 = 1'($urandom);
      chk("rst_outs1", int'({tx1, req1, busy1, done1}), 8);
      chk("rst_outs2", int'({tx2, req2, busy2, done2}), 8);
    end
    rnd = 1'b0;
    @(negedge clk); @(negedge clk);
    rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    repeat (20) @(negedge clk);
    chk("empty_no_req1", rc1, 0);
    chk("empty_no_req2", rc2, 0);
    chk("empty_tx_idle", int'(tx1), 1);

    // Single byte 0xA5
    push1(8'hA5);
    @(negedge clk);
    wait_low(w);
    chk("start_latency", w, 3);
    capture(1, 0, got);
    sb_check("byte_A5", got);
    chk("single_req", rc1, 1);

    // Back-to-back 0x00 then 0xFF
    base_r = rc1; base_d = dc1;
    push1(8'h00); push1(8'hFF);
    @(negedge clk);
    wait_low(w);
    capture(1, 0, got);
    sb_check("byte_00", got);
    wait_low(w);
    chk("b2b_gap", w, 3);
    capture(1, 0, got);
    sb_check("byte_FF", got);
    repeat (30) @(negedge clk);
    chk("b2b_reqs", rc1 - base_r, 2);
    chk("b2b_dones", dc1 - base_d, 2);

    // tx_enable drops during DATA bit 3 while two bytes are queued
    base_r = rc1;
    push1(8'h3C); push1(8'hC3);
    @(negedge clk);
    wait_low(w);
    capture(1, 4 * CPB + 1, got);
    sb_check("byte_3C", got);
    repeat (30) @(negedge clk);
    chk("disabled_no_req", rc1 - base_r, 1);
    chk("disabled_tx_idle", int'(tx1), 1);
    en1 = 1'b1;
    wait_low(w);
    chk("reenable_latency", w, 3);
    capture(1, 0, got);
    sb_check("byte_C3", got);

    // Missing data: the first read gets nothing, the second read succeeds
    base_r = rc1; base_d = dc1;
    drop1 = 1'b1;
    push1(8'h5A);
    @(negedge clk);
    wait_low(w);
    chk("retry_latency", w, 6);
    chk("retry_no_done", dc1 - base_d, 0);
    chk("retry_reqs", rc1 - base_r, 2);
    capture(1, 0, got);
    sb_check("byte_5A", got);

    // Async reset in the middle of DATA on the two-stop-bit instance
    sel = 1'b1;
    push2(8'h00); push2(8'h96);
    @(negedge clk);
    wait_low(w);
    chk("sb2_latency", w, 3);
    repeat (10) @(negedge clk);
    chk("sb2_mid_data_low", int'(tx2), 0);
    #2 rst2 = 1'b0;
    #1;
    chk("async_tx_high", int'(tx2), 1);
    chk("async_busy_low", int'(busy2), 0);
    void'(exp_q.pop_front());  // the byte in flight is lost
    @(negedge clk);
    rst2 = 1'b1;
    wait_low(w);
    chk("sb2_post_rst_latency", w, 3);
    capture(2, 0, got);
    sb_check("byte_96", got);
    chk("sb2_reqs", rc2, 2);

    chk("no_b2b_requests", b2b, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
